// File: rtl/mano_io_port.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mano_io_port : Mano terminal I/O unit (INPR/OUTR, FGI/FGO/IEN, valid/ready device side)
// Optional macro MANO_IO_ERR_EN enables the sticky ovr_err register. Rev 1.0
// ----------------------------------------------------------------------------
module mano_io_port #(
  parameter int W         = 8,
  parameter int OUT_DELAY = 2
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inp,
  input  logic         out,
  input  logic         ski,
  input  logic         sko,
  input  logic         ion,
  input  logic         iof,
  input  logic         int_ack,
  input  logic [W-1:0] ac_in,
  output logic [W-1:0] inpr,
  output logic         fgi,
  output logic         fgo,
  output logic         ien,
  output logic         skip,
  output logic         irq,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         ovr_err
);

  // A zero-delay build still needs a legal one-bit counter.
  localparam int              c_cnt_w     = (OUT_DELAY > 0) ? $clog2(OUT_DELAY + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_busy_load = (OUT_DELAY > 0) ? c_cnt_w'(OUT_DELAY - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [W-1:0]         r_inpr;
  logic [W-1:0]         r_outr;
  logic                 r_fgi;
  logic                 r_ien;
  logic                 w_accept;
  logic                 w_out_go;

  assign w_accept = in_valid & ~r_fgi;
  assign w_out_go = out & (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (out) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          if (OUT_DELAY == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = c_busy_load;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A device accept outranks a simultaneous INP (both only possible with FGI=0).
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_inpr <= '0;
      r_fgi  <= 1'b0;
      r_outr <= '0;
      r_ien  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_inpr <= in_data;
        r_fgi  <= 1'b1;
      end else if (inp) begin
        r_fgi  <= 1'b0;
      end
      if (w_out_go) r_outr <= ac_in;
      if (iof | int_ack) r_ien <= 1'b0;
      else if (ion)      r_ien <= 1'b1;
    end
  end

`ifdef MANO_IO_ERR_EN
  logic r_ovr;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                          r_ovr <= 1'b0;
    else if (out && (r_state != S_IDLE)) r_ovr <= 1'b1;
  end

  assign ovr_err = r_ovr;
`else
  assign ovr_err = 1'b0;
`endif

  // FGO is simply "output side idle"; SEND and BUSY both hold it low.
  assign fgo       = (r_state == S_IDLE);
  assign out_valid = (r_state == S_SEND);
  assign out_data  = r_outr;
  assign inpr      = r_inpr;
  assign fgi       = r_fgi;
  assign ien       = r_ien;
  assign in_ready  = ~r_fgi;
  assign skip      = (ski & r_fgi) | (sko & fgo);
  assign irq       = r_ien & (r_fgi | fgo);

endmodule
`default_nettype wire

// File: tb/tb_mano_io_port.sv
`default_nettype none
// tb_mano_io_port : directed and randomized checks of mano_io_port against a timestamp-based model.
module tb_mano_io_port;

  localparam int W         = 8;
  localparam int OUT_DELAY = 2;
`ifdef MANO_IO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clr_n;
  logic         inp, out, ski, sko, ion, iof, int_ack;
  logic [W-1:0] ac_in, in_data;
  logic         in_valid, out_ready;
  logic [W-1:0] inpr, out_data;
  logic         fgi, fgo, ien, skip, irq, in_ready, out_valid, ovr_err;

  int vecs = 0;
  int errs = 0;

  // Model: flags plus "device free at edge m_free" timestamp for FGO.
  logic [W-1:0] m_inpr, m_outr;
  bit           m_fgi, m_ien, m_ovr, m_send;
  int           m_n, m_free;

  mano_io_port #(.W(W), .OUT_DELAY(OUT_DELAY)) dut (
    .clk(clk), .clr_n(clr_n), .inp(inp), .out(out), .ski(ski), .sko(sko),
    .ion(ion), .iof(iof), .int_ack(int_ack), .ac_in(ac_in), .inpr(inpr),
    .fgi(fgi), .fgo(fgo), .ien(ien), .skip(skip), .irq(irq),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_fgo();
    return !m_send && (m_n >= m_free);
  endfunction

  task automatic idle_inputs();
    inp = 0; out = 0; ski = 0; sko = 0; ion = 0; iof = 0; int_ack = 0;
    in_valid = 0; out_ready = 0; ac_in = '0; in_data = '0;
  endtask

  task automatic model_reset();
    m_inpr = '0; m_outr = '0; m_fgi = 0; m_ien = 0; m_ovr = 0; m_send = 0;
    m_n = 0; m_free = 0;
  endtask

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic step();
    bit acc, f, snd;
    acc = in_valid && !m_fgi;
    f   = m_fgo();
    snd = m_send;
    m_n++;
    if (acc) begin m_inpr = in_data; m_fgi = 1; end
    else if (inp) m_fgi = 0;
    if (iof || int_ack) m_ien = 0;
    else if (ion)       m_ien = 1;
    if (out && f) begin m_outr = ac_in; m_send = 1; end
    if (out && !f && ERR_EN) m_ovr = 1;
    if (snd && out_ready) begin m_send = 0; m_free = m_n + OUT_DELAY; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    clr_n = 0;
    sko = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    vecs++; if (fgi !== 1'b0)       begin errs++; $display("FAIL reset_fgi got=%b exp=0", fgi); end
    vecs++; if (fgo !== 1'b1)       begin errs++; $display("FAIL reset_fgo got=%b exp=1", fgo); end
    vecs++; if (ien !== 1'b0)       begin errs++; $display("FAIL reset_ien got=%b exp=0", ien); end
    vecs++; if (in_ready !== 1'b1)  begin errs++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vecs++; if (inpr !== 8'h00)     begin errs++; $display("FAIL reset_inpr got=%h exp=00", inpr); end
    vecs++; if (out_data !== 8'h00) begin errs++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    vecs++; if (ovr_err !== 1'b0)   begin errs++; $display("FAIL reset_ovr got=%b exp=0", ovr_err); end
    vecs++; if (skip !== 1'b1)      begin errs++; $display("FAIL reset_skip_sko got=%b exp=1", skip); end
    clr_n = 1;
    sko = 0;
  endtask

  task automatic test_input();
    in_valid = 1; in_data = 8'h41;
    step();
    vecs++; if (inpr !== 8'h41)    begin errs++; $display("FAIL in_load got=%h exp=41", inpr); end
    vecs++; if (fgi !== 1'b1)      begin errs++; $display("FAIL in_fgi got=%b exp=1", fgi); end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL in_ready_low got=%b exp=0", in_ready); end
    in_data = 8'h42;
    step();
    vecs++; if (inpr !== 8'h41)    begin errs++; $display("FAIL in_blocked got=%h exp=41", inpr); end
    inp = 1;
    step();
    inp = 0;
    vecs++; if (fgi !== 1'b0)      begin errs++; $display("FAIL inp_clear got=%b exp=0", fgi); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL inp_ready got=%b exp=1", in_ready); end
    vecs++; if (inpr !== 8'h41)    begin errs++; $display("FAIL inp_keep got=%h exp=41", inpr); end
    step();
    vecs++; if (inpr !== 8'h42)    begin errs++; $display("FAIL in_second got=%h exp=42", inpr); end
    vecs++; if (fgi !== 1'b1)      begin errs++; $display("FAIL in_second_fgi got=%b exp=1", fgi); end
    in_valid = 0; inp = 1;
    step();
    inp = 0;
  endtask

  task automatic test_output();
    ac_in = 8'h5A; out = 1;
    step();
    out = 0; ac_in = 8'h00;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL out_valid_set got=%b exp=1", out_valid); end
    vecs++; if (fgo !== 1'b0)       begin errs++; $display("FAIL out_fgo_clr got=%b exp=0", fgo); end
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if (out_valid !== 1'b1 || out_data !== 8'h5A)
        begin errs++; $display("FAIL out_hold%0d got=%b/%h exp=1/5a", i, out_valid, out_data); end
    end
    out_ready = 1;
    step();
    out_ready = 0;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL out_hs_valid got=%b exp=0", out_valid); end
    vecs++; if (fgo !== 1'b0)       begin errs++; $display("FAIL out_hs_fgo got=%b exp=0", fgo); end
    // Overrun attempt while the device is still busy.
    out = 1; ac_in = 8'h33;
    step();
    out = 0;
    vecs++; if (out_data !== 8'h5A) begin errs++; $display("FAIL ovr_data got=%h exp=5a", out_data); end
    vecs++; if (fgo !== 1'b0)       begin errs++; $display("FAIL ovr_fgo got=%b exp=0", fgo); end
    vecs++; if (ovr_err !== ERR_EN) begin errs++; $display("FAIL ovr_flag got=%b exp=%b", ovr_err, ERR_EN); end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL ovr_valid got=%b exp=0", out_valid); end
    step();
    vecs++; if (fgo !== 1'b1)       begin errs++; $display("FAIL out_fgo_delay got=%b exp=1", fgo); end
  endtask

  task automatic test_ien();
    ion = 1;
    step();
    ion = 0;
    vecs++; if (ien !== 1'b1) begin errs++; $display("FAIL ion_set got=%b exp=1", ien); end
    vecs++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_fgo got=%b exp=1", irq); end
    in_valid = 1; in_data = 8'h10;
    step();
    in_valid = 0;
    ski = 1; #1;
    vecs++; if (irq !== 1'b1 || inpr !== 8'h10)
      begin errs++; $display("FAIL irq_accept got=%b/%h exp=1/10", irq, inpr); end
    vecs++; if (skip !== 1'b1) begin errs++; $display("FAIL ski_skip got=%b exp=1", skip); end
    ski = 0;
    ion = 1; iof = 1;
    step();
    ion = 0; iof = 0;
    vecs++; if (ien !== 1'b0 || irq !== 1'b0)
      begin errs++; $display("FAIL ion_iof got=%b/%b exp=0/0", ien, irq); end
    ion = 1;
    step();
    ion = 0; int_ack = 1;
    step();
    int_ack = 0;
    vecs++; if (ien !== 1'b0 || irq !== 1'b0)
      begin errs++; $display("FAIL int_ack got=%b/%b exp=0/0", ien, irq); end
    inp = 1;
    step();
    inp = 0;
  endtask

  task automatic test_reset_mid_send();
    ac_in = 8'hA5; out = 1;
    step();
    out = 0;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL rs_send got=%b exp=1", out_valid); end
    #2 clr_n = 0;
    #1;
    vecs++; if (out_valid !== 1'b0 || fgo !== 1'b1 || out_data !== 8'h00)
      begin errs++; $display("FAIL rs_async got=%b/%b/%h exp=0/1/00", out_valid, fgo, out_data); end
    vecs++; if (ovr_err !== 1'b0 || inpr !== 8'h00 || ien !== 1'b0)
      begin errs++; $display("FAIL rs_flags got=%b/%h/%b exp=0/00/0", ovr_err, inpr, ien); end
    @(posedge clk); #1;
    clr_n = 1;
    model_reset();
    ac_in = 8'h3C; out = 1;
    step();
    out = 0;
    vecs++; if (out_valid !== 1'b1 || out_data !== 8'h3C)
      begin errs++; $display("FAIL rs_after got=%b/%h exp=1/3c", out_valid, out_data); end
    out_ready = 1;
    step();
    out_ready = 0;
    step(); step();
    vecs++; if (fgo !== 1'b1) begin errs++; $display("FAIL rs_after_fgo got=%b exp=1", fgo); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = W'($urandom);
      inp       = ($urandom_range(0, 3) == 0);
      out       = ($urandom_range(0, 4) == 0);
      ac_in     = W'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      ski       = ($urandom_range(0, 1) == 1);
      sko       = ($urandom_range(0, 1) == 1);
      ion       = ($urandom_range(0, 5) == 0);
      iof       = ($urandom_range(0, 9) == 0);
      int_ack   = ($urandom_range(0, 15) == 0);
      #1;
      vecs++; if (skip !== ((ski && m_fgi) || (sko && m_fgo())))
        begin errs++; $display("FAIL rnd_skip[%0d] got=%b", i, skip); end
      vecs++; if (irq !== (m_ien && (m_fgi || m_fgo())) || in_ready !== !m_fgi)
        begin errs++; $display("FAIL rnd_irq_rdy[%0d] got=%b/%b exp=%b/%b", i, irq, in_ready, m_ien && (m_fgi || m_fgo()), !m_fgi); end
      step();
      vecs++; if (inpr !== m_inpr || fgi !== m_fgi || ien !== m_ien)
        begin errs++; $display("FAIL rnd_in[%0d] got=%h/%b/%b exp=%h/%b/%b", i, inpr, fgi, ien, m_inpr, m_fgi, m_ien); end
      vecs++; if (fgo !== m_fgo() || out_valid !== m_send || out_data !== m_outr)
        begin errs++; $display("FAIL rnd_out[%0d] got=%b/%b/%h exp=%b/%b/%h", i, fgo, out_valid, out_data, m_fgo(), m_send, m_outr); end
      vecs++; if (ovr_err !== m_ovr)
        begin errs++; $display("FAIL rnd_ovr[%0d] got=%b exp=%b", i, ovr_err, m_ovr); end
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    clr_n = 0;
    test_reset();
    test_input();
    test_output();
    test_ien();
    test_reset_mid_send();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
